// File: rtl/pcie_tx_arb_pkg.sv
`default_nettype none
// ============================================================================
// pcie_tx_arb_pkg : shared widths, FSM encoding and helpers for the tx arbiter
// Revision: 1.0
// ============================================================================
package pcie_tx_arb_pkg;

   localparam int DATA_W  = 64;
   localparam int KEEP_W  = 8;
   localparam int TUSER_W = 4;
   localparam int BEAT_W  = 10;
   localparam int IDX_W   = 4;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_XFER = 2'd1;
   localparam logic [1:0] S_CFG  = 2'd2;

   function automatic int rr_wrap(input int v, input int n);
      return v % n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pcie_rr_pick.sv
`default_nettype none
// ============================================================================
// pcie_rr_pick : combinational round-robin picker, first request after i_ptr
// Revision: 1.0
// ============================================================================
module pcie_rr_pick
   import pcie_tx_arb_pkg::*;
#(
   parameter int N  = 2,
   parameter int IW = 4
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic          o_valid,
   output logic [IW-1:0] o_idx
);

   int           w_base;
   logic [N-1:0] w_rot;

   // Rotate so bit 0 is the slot right after the pointer; the lowest set bit wins.
   always_comb begin
      w_base  = rr_wrap(int'(i_ptr) + 1, N);
      w_rot   = N'({i_req, i_req} >> w_base);
      o_valid = 1'b0;
      o_idx   = '0;
      for (int j = N - 1; j >= 0; j--) begin
         if (w_rot[j]) begin
            o_valid = 1'b1;
            o_idx   = IW'(rr_wrap(w_base + j, N));
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/pcie_tx_arbiter.sv
`default_nettype none
// ============================================================================
// pcie_tx_arbiter : packet-granular arbiter for the PCIe core tx AXI-stream,
//                   including the tx_cfg_req/tx_cfg_gnt handshake
// Revision: 1.0
// ============================================================================
module pcie_tx_arbiter
   import pcie_tx_arb_pkg::*;
#(
   parameter int NREQ      = 2,
   parameter int MAX_BEATS = 515,
   parameter int CFG_PRIO  = 1
) (
   input  logic                    user_clk,
   input  logic                    user_reset,
   input  logic [NREQ*64-1:0]      req_tdata,
   input  logic [NREQ*8-1:0]       req_tkeep,
   input  logic [NREQ-1:0]         req_tlast,
   input  logic [NREQ*4-1:0]       req_tuser,
   input  logic [NREQ-1:0]         req_tvalid,
   output logic [NREQ-1:0]         req_tready,
   output logic [63:0]             s_axis_tx_tdata,
   output logic [7:0]              s_axis_tx_tkeep,
   output logic                    s_axis_tx_tlast,
   output logic [3:0]              s_axis_tx_tuser,
   output logic                    s_axis_tx_tvalid,
   input  logic                    s_axis_tx_tready,
   input  logic                    tx_cfg_req,
   output logic                    tx_cfg_gnt,
   output logic [2:0]              grant_idx,
   output logic                    busy,
   output logic                    err_oversize
);

   logic [1:0]        r_state;
   logic [IDX_W-1:0]  r_sel;
   logic [IDX_W-1:0]  r_rr;
   logic [BEAT_W-1:0] r_beat_cnt;
   logic              r_err;

   logic              w_go_cfg;
   logic              w_go_req;
   logic [IDX_W-1:0]  w_pick_idx;
   logic [NREQ-1:0]   w_sel_oh;
   logic              w_sel_valid;
   logic              w_sel_last;
   logic              w_xfer;
   logic              w_beat;
   logic [BEAT_W:0]   w_cnt_inc;

   if (CFG_PRIO != 0) begin : g_cfg_prio
      logic             w_valid;
      logic [IDX_W-1:0] w_idx;

      pcie_rr_pick #(.N(NREQ), .IW(IDX_W)) u_pick (
         .i_req   (req_tvalid),
         .i_ptr   (r_rr),
         .o_valid (w_valid),
         .o_idx   (w_idx)
      );

      assign w_go_cfg   = tx_cfg_req;
      assign w_go_req   = w_valid & ~tx_cfg_req;
      assign w_pick_idx = w_idx;
   end else begin : g_cfg_rr
      logic             w_valid;
      logic [IDX_W-1:0] w_idx;

      // Config engine occupies the extra slot NREQ in the rotation.
      pcie_rr_pick #(.N(NREQ + 1), .IW(IDX_W)) u_pick (
         .i_req   ({tx_cfg_req, req_tvalid}),
         .i_ptr   (r_rr),
         .o_valid (w_valid),
         .o_idx   (w_idx)
      );

      assign w_go_cfg   = w_valid & (w_idx == IDX_W'(NREQ));
      assign w_go_req   = w_valid & (w_idx != IDX_W'(NREQ));
      assign w_pick_idx = w_idx;
   end

   assign w_sel_oh    = NREQ'(1) << r_sel;
   assign w_sel_valid = |(req_tvalid & w_sel_oh);
   assign w_sel_last  = |(req_tlast & w_sel_oh);
   assign w_xfer      = (r_state == S_XFER);
   assign w_beat      = w_xfer & w_sel_valid & s_axis_tx_tready;
   assign w_cnt_inc   = {1'b0, r_beat_cnt} + {{BEAT_W{1'b0}}, 1'b1};

   assign s_axis_tx_tdata  = w_xfer ? DATA_W'(req_tdata >> (DATA_W * int'(r_sel)))   : '0;
   assign s_axis_tx_tkeep  = w_xfer ? KEEP_W'(req_tkeep >> (KEEP_W * int'(r_sel)))   : '0;
   assign s_axis_tx_tuser  = w_xfer ? TUSER_W'(req_tuser >> (TUSER_W * int'(r_sel))) : '0;
   assign s_axis_tx_tlast  = w_xfer & w_sel_last;
   assign s_axis_tx_tvalid = w_xfer & w_sel_valid;
   assign req_tready       = w_xfer ? (w_sel_oh & {NREQ{s_axis_tx_tready}}) : '0;

   assign tx_cfg_gnt   = (r_state == S_CFG);
   assign busy         = (r_state != S_IDLE);
   assign grant_idx    = r_sel[2:0];
   assign err_oversize = r_err;

   always_ff @(posedge user_clk) begin
      if (user_reset) begin
         r_state    <= S_IDLE;
         r_sel      <= '0;
         r_rr       <= IDX_W'(NREQ - 1);
         r_beat_cnt <= '0;
         r_err      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_go_cfg) begin
                  r_state <= S_CFG;
               end else if (w_go_req) begin
                  r_sel   <= w_pick_idx;
                  r_state <= S_XFER;
               end
            end
            S_XFER: begin
               if (w_beat) begin
                  if (w_sel_last) begin
                     r_rr       <= r_sel;
                     r_beat_cnt <= '0;
                     r_state    <= S_IDLE;
                  end else begin
                     if (r_beat_cnt != '1) r_beat_cnt <= w_cnt_inc[BEAT_W-1:0];
                     // Flag only; the packet keeps flowing to its tlast.
                     if (w_cnt_inc >= (BEAT_W + 1)'(MAX_BEATS)) r_err <= 1'b1;
                  end
               end
            end
            S_CFG: begin
               if (!tx_cfg_req) begin
                  r_state <= S_IDLE;
                  if (CFG_PRIO == 0) r_rr <= IDX_W'(NREQ);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pcie_tx_arbiter.sv
`default_nettype none
// ============================================================================
// tb_pcie_tx_arbiter : scoreboard bench for pcie_tx_arbiter
// Revision: 1.0
// ============================================================================
module tb_pcie_tx_arbiter;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
      logic [3:0]  user;
   } beat_t;

   logic          user_clk;
   logic          user_reset;
   logic [127:0]  req_tdata;
   logic [15:0]   req_tkeep;
   logic [1:0]    req_tlast;
   logic [7:0]    req_tuser;
   logic [1:0]    req_tvalid;
   logic [1:0]    req_tready;
   logic [63:0]   s_axis_tx_tdata;
   logic [7:0]    s_axis_tx_tkeep;
   logic          s_axis_tx_tlast;
   logic [3:0]    s_axis_tx_tuser;
   logic          s_axis_tx_tvalid;
   logic          s_axis_tx_tready;
   logic          tx_cfg_req;
   logic          tx_cfg_gnt;
   logic [2:0]    grant_idx;
   logic          busy;
   logic          err_oversize;

   pcie_tx_arbiter #(.NREQ(2), .MAX_BEATS(515), .CFG_PRIO(1)) u_dut (
      .user_clk         (user_clk),
      .user_reset       (user_reset),
      .req_tdata        (req_tdata),
      .req_tkeep        (req_tkeep),
      .req_tlast        (req_tlast),
      .req_tuser        (req_tuser),
      .req_tvalid       (req_tvalid),
      .req_tready       (req_tready),
      .s_axis_tx_tdata  (s_axis_tx_tdata),
      .s_axis_tx_tkeep  (s_axis_tx_tkeep),
      .s_axis_tx_tlast  (s_axis_tx_tlast),
      .s_axis_tx_tuser  (s_axis_tx_tuser),
      .s_axis_tx_tvalid (s_axis_tx_tvalid),
      .s_axis_tx_tready (s_axis_tx_tready),
      .tx_cfg_req       (tx_cfg_req),
      .tx_cfg_gnt       (tx_cfg_gnt),
      .grant_idx        (grant_idx),
      .busy             (busy),
      .err_oversize     (err_oversize)
   );

   initial user_clk = 1'b0;
   always #5 user_clk = ~user_clk;

   beat_t src0[$];
   beat_t src1[$];
   beat_t exp_q[$];

   int    n_checks = 0;
   int    n_errors = 0;
   int    cyc      = 0;
   int    acc0     = 0;
   int    last_cyc = 0;
   bit    pop0, pop1;
   bit    nx_reset, nx_ready, nx_cfg;
   bit    mon_en, gap_en, pkt_open, have_last;
   bit [3:0] bp_pat = 4'b1001;

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic push_pkt(input int src, input int nbeats, input logic [7:0] tag,
                           input logic [7:0] last_keep, input bit with_last, input bit to_exp);
      for (int b = 0; b < nbeats; b++) begin
         beat_t bt;
         bt.data = {6'd0, src[1:0], tag, 16'(b), 32'($urandom)};
         bt.keep = (b == nbeats - 1) ? last_keep : 8'hFF;
         bt.last = with_last && (b == nbeats - 1);
         bt.user = 4'($urandom);
         if (src == 0) src0.push_back(bt);
         else          src1.push_back(bt);
         if (to_exp) exp_q.push_back(bt);
      end
   endtask

   task automatic monitor();
      beat_t e;
      if (mon_en && s_axis_tx_tvalid && s_axis_tx_tready && !user_reset) begin
         if (exp_q.size() == 0) begin
            check_val("unexpected_beat", {63'd0, s_axis_tx_tvalid}, 64'd0);
         end else begin
            e = exp_q.pop_front();
            check_val("beat_data", s_axis_tx_tdata, e.data);
            check_val("beat_ctrl", {51'd0, s_axis_tx_tkeep, s_axis_tx_tlast, s_axis_tx_tuser},
                      {51'd0, e.keep, e.last, e.user});
            if (!pkt_open && gap_en && have_last)
               check_val("rr_gap", 64'(cyc - last_cyc), 64'd2);
            pkt_open = 1'b1;
            if (s_axis_tx_tlast) begin
               pkt_open  = 1'b0;
               have_last = 1'b1;
               last_cyc  = cyc;
            end
         end
      end
   endtask

   // One clock: retire beats accepted at the last edge, drive, settle, observe.
   task automatic tick();
      @(negedge user_clk);
      if (pop0 && src0.size() > 0) begin void'(src0.pop_front()); acc0++; end
      if (pop1 && src1.size() > 0) void'(src1.pop_front());
      user_reset       = nx_reset;
      s_axis_tx_tready = nx_ready;
      tx_cfg_req       = nx_cfg;
      req_tvalid = '0; req_tdata = '0; req_tkeep = '0; req_tlast = '0; req_tuser = '0;
      if (src0.size() > 0) begin
         req_tvalid[0]     = 1'b1;
         req_tdata[63:0]   = src0[0].data;
         req_tkeep[7:0]    = src0[0].keep;
         req_tlast[0]      = src0[0].last;
         req_tuser[3:0]    = src0[0].user;
      end
      if (src1.size() > 0) begin
         req_tvalid[1]     = 1'b1;
         req_tdata[127:64] = src1[0].data;
         req_tkeep[15:8]   = src1[0].keep;
         req_tlast[1]      = src1[0].last;
         req_tuser[7:4]    = src1[0].user;
      end
      #1;
      cyc++;
      pop0 = req_tvalid[0] & req_tready[0] & ~user_reset;
      pop1 = req_tvalid[1] & req_tready[1] & ~user_reset;
      monitor();
   endtask

   task automatic drain(input string tag, input int max_cyc);
      for (int i = 0; i < max_cyc && exp_q.size() > 0; i++) tick();
      check_val({"drain_", tag}, 64'(exp_q.size()), 64'd0);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      user_reset = 1'b1; s_axis_tx_tready = 1'b1; tx_cfg_req = 1'b0;
      req_tvalid = '0; req_tdata = '0; req_tkeep = '0; req_tlast = '0; req_tuser = '0;
      nx_reset = 1'b1; nx_ready = 1'b1; nx_cfg = 1'b0;
      pop0 = 1'b0; pop1 = 1'b0;
      mon_en = 1'b1; gap_en = 1'b0; pkt_open = 1'b0; have_last = 1'b0;

      // Reset state
      repeat (3) tick();
      nx_reset = 1'b0;
      tick();
      check_val("rst_tvalid", {63'd0, s_axis_tx_tvalid}, 64'd0);
      check_val("rst_ctrl", {51'd0, s_axis_tx_tkeep, s_axis_tx_tlast, s_axis_tx_tuser}, 64'd0);
      check_val("rst_tdata", s_axis_tx_tdata, 64'd0);
      check_val("rst_status", {56'd0, req_tready, tx_cfg_gnt, grant_idx, busy, err_oversize}, 64'd0);

      // Round robin: 0,1,0,1 with one dead cycle between packets
      gap_en = 1'b1; have_last = 1'b0;
      push_pkt(0, 4, 8'h01, 8'hFF, 1'b1, 1'b1);
      push_pkt(1, 4, 8'h02, 8'hFF, 1'b1, 1'b1);
      push_pkt(0, 4, 8'h03, 8'hFF, 1'b1, 1'b1);
      push_pkt(1, 4, 8'h04, 8'hFF, 1'b1, 1'b1);
      drain("rr", 60);
      gap_en = 1'b0;

      // Single requester, 3-DW MRd
      push_pkt(0, 2, 8'h05, 8'h0F, 1'b1, 1'b1);
      tick();
      check_val("arb_lat_tvalid", {63'd0, s_axis_tx_tvalid}, 64'd0);
      tick();
      check_val("single_tvalid", {63'd0, s_axis_tx_tvalid}, 64'd1);
      check_val("single_grant", {61'd0, grant_idx}, 64'd0);
      check_val("single_busy", {63'd0, busy}, 64'd1);
      tick();
      check_val("single_tlast", {63'd0, s_axis_tx_tlast}, 64'd1);
      tick();
      check_val("single_idle", {63'd0, busy}, 64'd0);

      // Backpressure on a 7-DW write from req1 while req0 waits
      push_pkt(1, 4, 8'h06, 8'h0F, 1'b1, 1'b1);
      push_pkt(0, 1, 8'h07, 8'hFF, 1'b1, 1'b1);
      for (int i = 0; i < 80 && exp_q.size() > 0; i++) begin
         nx_ready = bp_pat[i % 4];
         tick();
         if (busy && grant_idx == 3'd1)
            check_val("bp_other_ready", {63'd0, req_tready[0]}, 64'd0);
      end
      check_val("drain_bp", 64'(exp_q.size()), 64'd0);
      nx_ready = 1'b1;
      tick();

      // tx_cfg_req raised mid-packet
      push_pkt(0, 4, 8'h08, 8'hFF, 1'b1, 1'b1);
      tick(); tick(); tick();
      nx_cfg = 1'b1;
      tick();
      check_val("cfg_hold_mid", {63'd0, tx_cfg_gnt}, 64'd0);
      tick();
      check_val("cfg_hold_last", {62'd0, s_axis_tx_tlast, tx_cfg_gnt}, 64'd2);
      tick();
      check_val("cfg_idle_gnt", {63'd0, tx_cfg_gnt}, 64'd0);
      push_pkt(0, 1, 8'h09, 8'hFF, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_val("cfg_gnt", {63'd0, tx_cfg_gnt}, 64'd1);
         check_val("cfg_quiet", {61'd0, s_axis_tx_tvalid, req_tready}, 64'd0);
      end
      nx_cfg = 1'b0;
      tick();
      check_val("cfg_gnt_lag", {63'd0, tx_cfg_gnt}, 64'd1);
      tick();
      check_val("cfg_gnt_drop", {63'd0, tx_cfg_gnt}, 64'd0);
      drain("cfg", 20);

      // Oversize TLP, then reset mid-packet
      mon_en = 1'b0; acc0 = 0;
      push_pkt(0, 600, 8'h0A, 8'hFF, 1'b0, 1'b0);
      for (int i = 0; i < 700 && acc0 < 520; i++) begin
         tick();
         if (acc0 == 514) check_val("ovs_before", {63'd0, err_oversize}, 64'd0);
         if (acc0 == 515) check_val("ovs_at_515", {63'd0, err_oversize}, 64'd1);
      end
      check_val("ovs_beats", 64'(acc0), 64'd520);
      check_val("ovs_sticky", {62'd0, err_oversize, busy}, 64'd3);
      nx_reset = 1'b1;
      tick();
      src0.delete();
      nx_reset = 1'b0;
      tick();
      check_val("mrst_tvalid", {63'd0, s_axis_tx_tvalid}, 64'd0);
      check_val("mrst_tdata", s_axis_tx_tdata, 64'd0);
      check_val("mrst_status", {56'd0, req_tready, tx_cfg_gnt, grant_idx, busy, err_oversize}, 64'd0);

      // Both pending after reset: req0 must win first
      mon_en = 1'b1; pkt_open = 1'b0;
      push_pkt(0, 1, 8'h0B, 8'hFF, 1'b1, 1'b1);
      push_pkt(1, 1, 8'h0C, 8'hFF, 1'b1, 1'b1);
      drain("post_rst", 20);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
